// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
//   state_t      : arbiter FSM states
//   ERR_ACK/OVF  : bit positions inside the sticky err vector
//   owner_width  : index width for a given producer count (min 1)
//   cnt_width    : beat counter width for a given burst limit
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int ERR_ACK = 0;
  localparam int ERR_OVF = 1;

  function automatic int owner_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int m);
    return $clog2(m) + 1;
  endfunction

  // Widths for the default configuration (NUM_REQ=4, MAX_BURST=4).
  localparam int OWNER_W = owner_width(4);
  localparam int CNT_W   = cnt_width(4);

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of producer-side and FIFO-side signals of the write arbiter.
//   master : arbiter view (drives gnt, FIFO write side, status)
//   slave  : environment view (drives requests/data and FIFO status)
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 8,
  parameter int OWNER_W    = fifo_arb_pkg::OWNER_W
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;
  logic                          fifo_wr_ack;
  logic                          fifo_overflow;
  logic [OWNER_W-1:0]            owner;
  logic                          busy;
  logic [1:0]                    err;

  modport master (
    input  req, data, fifo_full, fifo_wr_ack, fifo_overflow,
    output gnt, fifo_wr_en, fifo_data_in, owner, busy, err
  );

  modport slave (
    output req, data, fifo_full, fifo_wr_ack, fifo_overflow,
    input  gnt, fifo_wr_en, fifo_data_in, owner, busy, err
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i   : request vector
//   last_i  : index of the previous owner; search starts one above it
//   found_o : at least one request present
//   idx_o   : first requester at or after (last_i+1) mod NUM_REQ, with wrap
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  int unsigned          start;

  always_comb begin
    start = (32'(last_i) + 32'd1) % NUM_REQ;
    // Rotate so the highest-priority requester lands at bit 0, then take
    // the lowest set bit and map it back to an absolute index.
    dbl     = {req_i, req_i} >> start;
    rot     = dbl[NUM_REQ-1:0];
    found_o = 1'b0;
    idx_o   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (rot[k] && !found_o) begin
        found_o = 1'b1;
        idx_o   = IDX_W'((start + k) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers,
// with bursts bounded to MAX_BURST accepted beats per grant.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : producer req/data/gnt, FIFO wr_en/data_in/full/wr_ack/overflow,
//              owner index, busy (in BURST), sticky err {overflow, ack}
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input logic                clk,
  input logic                rst,
  fifo_wr_arbiter_if.master  bus
);
  localparam int OW = owner_width(NUM_REQ);
  localparam int CW = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
  localparam logic [OW-1:0] LAST_INIT = OW'(NUM_REQ - 1);

  state_t                state_q, state_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [OW-1:0]         last_q, last_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            err_q, err_d;
  logic                  wr_en_q;
  logic                  wr_en;
  logic                  pick_found;
  logic [OW-1:0]         pick_idx;
  logic                  req_own;
  logic [FIFO_WIDTH-1:0] data_own;
  logic [FIFO_WIDTH-1:0] data_out;
  logic [NUM_REQ-1:0]    gnt;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OW)
  ) u_pick (
    .req_i   (bus.req),
    .last_i  (last_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    req_own  = 1'b0;
    data_own = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OW'(i)) begin
        req_own  = bus.req[i];
        data_own = bus.data[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    wr_en    = 1'b0;
    gnt      = '0;
    data_out = '0;
    case (state_q)
      IDLE: begin
        if (pick_found && !bus.fifo_full) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        wr_en    = req_own & ~bus.fifo_full;
        data_out = data_own;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          gnt[i] = wr_en && (owner_q == OW'(i));
        end
        // A full FIFO only stalls; the burst ends on a dropped request or
        // on the beat that reaches the burst limit.
        if (!req_own) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else if (wr_en) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            last_d  = owner_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    // Every write must be acked exactly one cycle later, and no ack may
    // arrive without a write; either mismatch is an ack error.
    if (wr_en_q != bus.fifo_wr_ack) err_d[ERR_ACK] = 1'b1;
    if (bus.fifo_overflow)          err_d[ERR_OVF] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_INIT;
      cnt_q   <= '0;
      err_q   <= '0;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wr_en_q <= wr_en;
    end
  end

  assign bus.gnt          = gnt;
  assign bus.fifo_wr_en   = wr_en;
  assign bus.fifo_data_in = data_out;
  assign bus.owner        = owner_q;
  assign bus.busy         = (state_q == BURST);
  assign bus.err          = err_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, FIFO_WIDTH=8,
// MAX_BURST=4). Producer i presents data {i[1:0], seq[5:0]}; expected beats
// are queued when a scenario starts and popped as FIFO writes appear.
module tb_fifo_wr_arbiter;

  typedef struct {
    logic [1:0] prod;
    logic [7:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int         total = 0;
  int         bad   = 0;
  int         rem [4];
  logic [5:0] seq [4];
  logic       ack_en    = 1'b1;
  logic       ack_force = 1'b0;
  beat_t      exp_q [$];

  fifo_wr_arbiter_if #(.NUM_REQ(4), .FIFO_WIDTH(8), .OWNER_W(2)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .FIFO_WIDTH (8),
    .MAX_BURST  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic drive_prod();
    for (int i = 0; i < 4; i++) begin
      bus.req[i]          = (rem[i] != 0);
      bus.data[i*8 +: 8]  = {2'(i), seq[i]};
    end
  endtask

  task automatic push(input int p, input int s);
    beat_t b;
    b.prod = 2'(p);
    b.data = {2'(p), 6'(s)};
    exp_q.push_back(b);
  endtask

  // One clock cycle: sample at negedge (scoreboard pops on each write),
  // then after the edge update producers and return the FIFO ack.
  task automatic tick(output logic [3:0] g, output logic we, output logic b,
                      output logic [1:0] own, output logic [1:0] e);
    beat_t x;
    @(negedge clk);
    g   = bus.gnt;
    we  = bus.fifo_wr_en;
    b   = bus.busy;
    own = bus.owner;
    e   = bus.err;
    if (we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got data=%h gnt=%b, required no write", bus.fifo_data_in, g);
      end else begin
        x = exp_q.pop_front();
        if (bus.fifo_data_in !== x.data || g !== (4'b0001 << x.prod)) begin
          bad++;
          $display("FAIL sb_beat: got data=%h gnt=%b, required data=%h gnt=%b",
                   bus.fifo_data_in, g, x.data, 4'b0001 << x.prod);
        end
      end
    end
    @(posedge clk);
    #1;
    bus.fifo_wr_ack = (we & ack_en) | ack_force;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) begin
        rem[i]--;
        seq[i]++;
      end
    end
    drive_prod();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0;
      seq[i] = '0;
    end
    bus.fifo_full     = 1'b0;
    bus.fifo_wr_ack   = 1'b0;
    bus.fifo_overflow = 1'b0;
    ack_en    = 1'b1;
    ack_force = 1'b0;
    exp_q.delete();
    drive_prod();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) rem[i] = 5;
    drive_prod();
    @(negedge clk);
    total += 6;
    if (bus.gnt !== 4'b0)          begin bad++; $display("FAIL rst_gnt: got %b required 0000", bus.gnt); end
    if (bus.fifo_wr_en !== 1'b0)   begin bad++; $display("FAIL rst_wr_en: got %b required 0", bus.fifo_wr_en); end
    if (bus.fifo_data_in !== 8'h0) begin bad++; $display("FAIL rst_data: got %h required 00", bus.fifo_data_in); end
    if (bus.busy !== 1'b0)         begin bad++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
    if (bus.owner !== 2'd0)        begin bad++; $display("FAIL rst_owner: got %0d required 0", bus.owner); end
    if (bus.err !== 2'b00)         begin bad++; $display("FAIL rst_err: got %b required 00", bus.err); end
  endtask

  task automatic test_single();
    int gx [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
    int bx [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
    logic [3:0] g; logic we, b; logic [1:0] own, e;
    do_reset();
    rem[0] = 6;
    drive_prod();
    for (int k = 0; k < 6; k++) push(0, k);
    for (int c = 0; c < 10; c++) begin
      tick(g, we, b, own, e);
      total += 2;
      if (g !== 4'(gx[c])) begin bad++; $display("FAIL single_gnt c%0d: got %b required %b", c, g, 4'(gx[c])); end
      if (b !== 1'(bx[c])) begin bad++; $display("FAIL single_busy c%0d: got %b required %b", c, b, 1'(bx[c])); end
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL single_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_all_rr();
    logic [3:0] g; logic we, b; logic [1:0] own, e;
    logic [3:0] ge;
    int p;
    do_reset();
    for (int i = 0; i < 4; i++) rem[i] = 100;
    drive_prod();
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 4; j++) push(k % 4, (k / 4) * 4 + j);
    for (int c = 0; c < 25; c++) begin
      tick(g, we, b, own, e);
      p  = ((c - 1) / 5) % 4;
      ge = (c == 0 || ((c - 1) % 5) == 4) ? 4'b0 : (4'b0001 << p);
      total += 2;
      if (g !== ge) begin bad++; $display("FAIL rr_gnt c%0d: got %b required %b", c, g, ge); end
      if (b !== (ge != 4'b0)) begin bad++; $display("FAIL rr_busy c%0d: got %b required %b", c, b, ge != 4'b0); end
      if (ge != 4'b0) begin
        total++;
        if (own !== 2'(p)) begin bad++; $display("FAIL rr_owner c%0d: got %0d required %0d", c, own, p); end
      end
    end
    total += 2;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rr_drain: got %0d pending required 0", exp_q.size()); end
    if (e !== 2'b00) begin bad++; $display("FAIL rr_err: got %b required 00", e); end
  endtask

  task automatic test_full_stall();
    int gx [20] = '{0, 2, 2, 0, 0, 0, 2, 2, 0, 4, 4, 4, 4, 0, 0, 0, 0, 8, 0, 0};
    logic [3:0] g; logic we, b; logic [1:0] own, e;
    do_reset();
    rem[1] = 4;
    rem[2] = 4;
    drive_prod();
    for (int k = 0; k < 4; k++) push(1, k);
    for (int k = 0; k < 4; k++) push(2, k);
    push(3, 0);
    for (int c = 0; c < 20; c++) begin
      bus.fifo_full = (c >= 3 && c <= 5) || (c == 14) || (c == 15);
      if (c == 14) begin
        rem[3] = 1;
        drive_prod();
      end
      tick(g, we, b, own, e);
      total++;
      if (g !== 4'(gx[c])) begin bad++; $display("FAIL full_gnt c%0d: got %b required %b", c, g, 4'(gx[c])); end
      if (c >= 3 && c <= 5) begin
        total += 3;
        if (we !== 1'b0)  begin bad++; $display("FAIL full_wr_en c%0d: got %b required 0", c, we); end
        if (own !== 2'd1) begin bad++; $display("FAIL full_owner c%0d: got %0d required 1", c, own); end
        if (b !== 1'b1)   begin bad++; $display("FAIL full_busy c%0d: got %b required 1", c, b); end
      end
      if (c == 9) begin
        total++;
        if (own !== 2'd2) begin bad++; $display("FAIL full_next_owner: got %0d required 2", own); end
      end
      if (c == 14 || c == 15) begin
        total++;
        if (b !== 1'b0) begin bad++; $display("FAIL full_idle_hold c%0d: got busy %b required 0", c, b); end
      end
    end
    bus.fifo_full = 1'b0;
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL full_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_req_drop();
    int gx [10] = '{0, 1, 1, 0, 0, 8, 8, 8, 8, 0};
    logic [3:0] g; logic we, b; logic [1:0] own, e;
    do_reset();
    rem[0] = 2;
    rem[3] = 10;
    drive_prod();
    push(0, 0);
    push(0, 1);
    for (int k = 0; k < 4; k++) push(3, k);
    for (int c = 0; c < 10; c++) begin
      tick(g, we, b, own, e);
      total++;
      if (g !== 4'(gx[c])) begin bad++; $display("FAIL drop_gnt c%0d: got %b required %b", c, g, 4'(gx[c])); end
      if (c == 3) begin
        total++;
        if (b !== 1'b1) begin bad++; $display("FAIL drop_busy: got %b required 1", b); end
      end
      if (c == 5) begin
        total++;
        if (own !== 2'd3) begin bad++; $display("FAIL drop_owner: got %0d required 3", own); end
      end
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL drop_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_errors();
    int ex [8] = '{0, 0, 0, 1, 1, 1, 3, 3};
    logic [3:0] g; logic we, b; logic [1:0] own, e;
    do_reset();
    ack_en = 1'b0;
    rem[0] = 1;
    drive_prod();
    push(0, 0);
    for (int c = 0; c < 8; c++) begin
      bus.fifo_overflow = (c == 5);
      tick(g, we, b, own, e);
      total++;
      if (e !== 2'(ex[c])) begin bad++; $display("FAIL err_bits c%0d: got %b required %b", c, e, 2'(ex[c])); end
    end
    bus.fifo_overflow = 1'b0;
  endtask

  task automatic test_spurious_ack();
    int ex [3] = '{0, 0, 1};
    logic [3:0] g; logic we, b; logic [1:0] own, e;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      ack_force = (c == 0);
      tick(g, we, b, own, e);
      total++;
      if (e !== 2'(ex[c])) begin bad++; $display("FAIL spur_ack c%0d: got %b required %b", c, e, 2'(ex[c])); end
    end
    ack_force = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [3:0] g; logic we, b; logic [1:0] own, e;
    do_reset();
    for (int i = 0; i < 4; i++) rem[i] = 100;
    drive_prod();
    for (int k = 0; k < 4; k++) push(0, k);
    push(1, 0);
    push(1, 1);
    for (int c = 0; c < 8; c++) tick(g, we, b, own, e);
    #2;
    total++;
    if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL ar_pre_gnt: got %b required 0010", bus.gnt); end
    rst = 1'b1;
    #1;
    total += 5;
    if (bus.gnt !== 4'b0)          begin bad++; $display("FAIL ar_gnt: got %b required 0000", bus.gnt); end
    if (bus.fifo_wr_en !== 1'b0)   begin bad++; $display("FAIL ar_wr_en: got %b required 0", bus.fifo_wr_en); end
    if (bus.fifo_data_in !== 8'h0) begin bad++; $display("FAIL ar_data: got %h required 00", bus.fifo_data_in); end
    if (bus.busy !== 1'b0)         begin bad++; $display("FAIL ar_busy: got %b required 0", bus.busy); end
    if (bus.owner !== 2'd0)        begin bad++; $display("FAIL ar_owner: got %0d required 0", bus.owner); end
    bus.fifo_wr_ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 4; k < 8; k++) push(0, k);
    for (int c = 0; c < 6; c++) begin
      tick(g, we, b, own, e);
      if (c == 1) begin
        total += 2;
        if (g !== 4'b0001) begin bad++; $display("FAIL ar_first_gnt: got %b required 0001", g); end
        if (own !== 2'd0)  begin bad++; $display("FAIL ar_first_owner: got %0d required 0", own); end
      end
    end
    total += 2;
    if (exp_q.size() != 0) begin bad++; $display("FAIL ar_drain: got %0d pending required 0", exp_q.size()); end
    if (e !== 2'b00) begin bad++; $display("FAIL ar_err: got %b required 00", e); end
  endtask

  initial begin
    bus.fifo_full     = 1'b0;
    bus.fifo_wr_ack   = 1'b0;
    bus.fifo_overflow = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0;
      seq[i] = '0;
    end
    drive_prod();
    test_reset();
    test_single();
    test_all_rr();
    test_full_stall();
    test_req_drop();
    test_errors();
    test_spurious_ack();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule
